// File: rtl/gcm_aes_pkg.sv
// gcm_aes_pkg: GHASH input-select codes, sequencer state encoding and the
// frame entry-state helper shared by the GCM-AES tag sequencer.
package gcm_aes_pkg;

    localparam int NB_SEL_DEFAULT = 2;

    localparam int SEL_DATA   = 0;
    localparam int SEL_LENGTH = 1;
    localparam int SEL_AAD    = 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_AAD    = 2'd1;
    localparam logic [1:0] ST_DATA   = 2'd2;
    localparam logic [1:0] ST_LENGTH = 2'd3;

    // Empty phases are skipped so a frame never waits on a block it does not have.
    function automatic logic [1:0] first_state(input logic aad_nz, input logic pt_nz);
        return aad_nz ? ST_AAD : pt_nz ? ST_DATA : ST_LENGTH;
    endfunction

endpackage

// File: rtl/gcm_aes_valid_delay_line.sv
// gcm_aes_valid_delay_line: DEPTH-stage single-bit shift register advancing
// only on enabled cycles; the output is the last stage.
module gcm_aes_valid_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_valid,
    input  logic i_data,
    output logic o_data
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    always_comb sr_d = i_valid ? (sr_q << 1) | DEPTH'(i_data) : sr_q;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) sr_q <= '0;
        else            sr_q <= sr_d;
    end

    assign o_data = sr_q[DEPTH-1];

endmodule

// File: rtl/gcm_aes_tag_sequencer.sv
// gcm_aes_tag_sequencer: walks each GCM frame through AAD, data and length
// blocks, steering the GHASH input mux and emitting a delayed tag-valid pulse.
module gcm_aes_tag_sequencer
    import gcm_aes_pkg::*;
#(
    parameter int NB_LEN_AAD  = 8,
    parameter int NB_LEN_DATA = 16,
    parameter int NB_SEL      = NB_SEL_DEFAULT,
    parameter int TAG_LATENCY = 2
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic                   i_valid,
    input  logic                   i_sop,
    input  logic [NB_LEN_AAD-1:0]  i_length_aad,
    input  logic [NB_LEN_DATA-1:0] i_length_plaintext,
    input  logic                   i_valid_data,
    output logic [NB_SEL-1:0]      o_sel_ghash_in,
    output logic                   o_valid_aad,
    output logic                   o_valid_data,
    output logic                   o_valid_length,
    output logic                   o_valid_ghash,
    output logic                   o_valid_ghash_d,
    output logic                   o_valid_tag,
    output logic                   o_busy,
    output logic                   o_error
);

    logic [1:0]             state_q, state_d;
    logic [NB_LEN_AAD-1:0]  len_aad_q, len_aad_d, aad_cnt_q, aad_cnt_d;
    logic [NB_LEN_DATA-1:0] len_pt_q, len_pt_d, data_cnt_q, data_cnt_d;
    logic                   ghash_d_q, ghash_d_d;
    logic                   error_q, error_d;
    logic                   aad_last, data_last;

    // A SOP cycle carries no data word, so every strobe is masked by it.
    assign o_valid_aad    = i_valid & ~i_sop & i_valid_data & (state_q == ST_AAD);
    assign o_valid_data   = i_valid & ~i_sop & i_valid_data & (state_q == ST_DATA);
    assign o_valid_length = i_valid & ~i_sop & (state_q == ST_LENGTH);
    assign o_valid_ghash  = o_valid_aad | o_valid_data | o_valid_length;
    assign o_busy         = state_q != ST_IDLE;
    assign o_sel_ghash_in = state_q == ST_AAD    ? NB_SEL'(SEL_AAD)
                          : state_q == ST_LENGTH ? NB_SEL'(SEL_LENGTH)
                          :                        NB_SEL'(SEL_DATA);
    assign o_valid_ghash_d = ghash_d_q;
    assign o_error         = error_q;

    assign aad_last  = aad_cnt_q == len_aad_q - NB_LEN_AAD'(1);
    assign data_last = data_cnt_q == len_pt_q - NB_LEN_DATA'(1);

    always_comb begin
        state_d    = state_q;
        len_aad_d  = len_aad_q;
        len_pt_d   = len_pt_q;
        aad_cnt_d  = aad_cnt_q;
        data_cnt_d = data_cnt_q;
        ghash_d_d  = ghash_d_q;
        error_d    = error_q;
        if (i_valid) begin
            ghash_d_d = o_valid_ghash;
            error_d   = i_sop && state_q != ST_IDLE;
            if (i_sop) begin
                state_d    = first_state(i_length_aad != '0, i_length_plaintext != '0);
                len_aad_d  = i_length_aad;
                len_pt_d   = i_length_plaintext;
                aad_cnt_d  = '0;
                data_cnt_d = '0;
            end else if (o_valid_aad) begin
                aad_cnt_d = aad_cnt_q + NB_LEN_AAD'(1);
                if (aad_last) state_d = len_pt_q != '0 ? ST_DATA : ST_LENGTH;
            end else if (o_valid_data) begin
                data_cnt_d = data_cnt_q + NB_LEN_DATA'(1);
                if (data_last) state_d = ST_LENGTH;
            end else if (state_q == ST_LENGTH) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            len_aad_q  <= '0;
            len_pt_q   <= '0;
            aad_cnt_q  <= '0;
            data_cnt_q <= '0;
            ghash_d_q  <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_aad_q  <= len_aad_d;
            len_pt_q   <= len_pt_d;
            aad_cnt_q  <= aad_cnt_d;
            data_cnt_q <= data_cnt_d;
            ghash_d_q  <= ghash_d_d;
            error_q    <= error_d;
        end
    end

    gcm_aes_valid_delay_line #(
        .DEPTH (TAG_LATENCY)
    ) u_tag_delay (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_valid   (i_valid),
        .i_data    (o_valid_length),
        .o_data    (o_valid_tag)
    );

endmodule

// File: doc/gcm_aes_tag_sequencer.md
# gcm_aes_tag_sequencer

Parametrised GHASH input sequencer and tag-valid generator for the GCM-AES datapath, sitting between the AES-CTR keystream stage and the GHASH multiplier. It walks each frame through AAD blocks, ciphertext blocks and the final length block, driving the GHASH input mux select and valid strobes. It also issues a tag-valid pulse a programmable number of cycles after the length block. Successor of the single-phase tag FSM: it adds an AAD phase, wider programmable lengths, a configurable tag latency, and mid-frame SOP abort handling.

## Interface
- NB_LEN_AAD, 8: width of AAD block count.
- NB_LEN_DATA, 16: width of plaintext block count.
- NB_SEL, 2: width of GHASH input select.
- TAG_LATENCY, 2: enabled cycles from the length strobe to `o_valid_tag`; ≥1.

- i_clock  in  1  clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  global clock enable; all state advances only when high.
- i_sop  in  1  start of frame; latches lengths and carries no data word.
- i_length_aad  in  NB_LEN_AAD  AAD blocks in the frame; 0 means none.
- i_length_plaintext  in  NB_LEN_DATA  data blocks in the frame; 0 means none.
- i_valid_data  in  1  a 128-bit block is present on the datapath this cycle.
- o_sel_ghash_in  out  NB_SEL  SEL_DATA=0, SEL_LENGTH=1, SEL_AAD=2.
- o_valid_aad  out  1  combinational; AAD block accepted.
- o_valid_data  out  1  combinational; data block accepted.
- o_valid_length  out  1  combinational; length block cycle.
- o_valid_ghash  out  1  OR of the three strobes above.
- o_valid_ghash_d  out  1  `o_valid_ghash` registered under i_valid.
- o_valid_tag  out  1  registered tag-valid pulse.
- o_busy  out  1  state ≠ IDLE.
- o_error  out  1  registered one-cycle pulse on SOP abort.

## Operation
- States: IDLE, AAD, DATA, LENGTH. Lengths are latched on SOP. `aad_cnt` and `data_cnt` are cleared on SOP.
- IDLE + `i_valid & i_sop`:
  - go to AAD if len_aad ≠ 0;
  - else go to DATA if len_pt ≠ 0;
  - else go to LENGTH.
- AAD:
  - `o_valid_aad = i_valid_data`; sel = SEL_AAD.
  - Each accepted block increments `aad_cnt`.
  - On the block where `aad_cnt == len_aad-1`, go to DATA, or to LENGTH if len_pt == 0.
- DATA:
  - `o_valid_data = i_valid_data`; sel = SEL_DATA.
  - On the block where `data_cnt == len_pt-1`, go to LENGTH.
- LENGTH:
  - Lasts exactly one enabled cycle, independent of `i_valid_data`.
  - `o_valid_length = 1`, sel = SEL_LENGTH; then go to IDLE.
- Combinational strobes are qualified by `i_valid`.
- IDLE outputs: sel = SEL_DATA, all strobes 0. `i_valid_data` in IDLE is ignored.
- Any SOP cycle ignores `i_valid_data`.
- SOP in AAD, DATA or LENGTH:
  - abort the current frame (no length strobe for it);
  - pulse `o_error` next enabled cycle;
  - restart exactly as from IDLE with the new lengths.
- Tag delay:
  - TAG_LATENCY-deep shift register fed by `o_valid_length`, shifting on `i_valid`; `o_valid_tag` is its last stage.
  - Frames may overlap; an abort does not flush tags already in flight.
- Counters saturate at neither end. The last-block compare prevents overflow, and `len-1` with len=0 is never evaluated.

## Timing
- Reset (asynchronous assert, synchronous deassert by the clocking scheme):
  - state = IDLE; counters = 0; shift register = 0.
  - `o_valid_ghash_d`, `o_valid_tag`, `o_error` = 0.
  - Combinational outputs therefore 0, and sel = SEL_DATA.
- Reset mid-frame drops the frame and any pending tag.
- SOP at enabled cycle t:
  - first AAD/data block can be accepted at t+1;
  - length strobe at the enabled cycle after the last block.
- `o_valid_tag` rises TAG_LATENCY enabled cycles after the length cycle.
- `i_valid` low freezes all registers and forces combinational strobes to 0.
- Back-to-back frames: SOP in the cycle after LENGTH is legal (state is IDLE).
- SOP coincident with LENGTH counts as an abort.

## Structure
- Shared package `gcm_aes_pkg` holds:
  - SEL_DATA, SEL_LENGTH, SEL_AAD;
  - state encoding localparams;
  - NB_SEL default.
- One sub-module: `gcm_aes_valid_delay_line` (parameter DEPTH; `i_valid` enable; async active-low reset), reused for the tag delay.

## Test plan
- len_aad=2, len_pt=3, `i_valid` always 1, blocks every cycle after SOP@0:
  - AAD strobes at 1–2, data at 3–5, length at 6;
  - `o_valid_tag` at 8 (TAG_LATENCY=2);
  - sel sequence 2,2,0,0,0,1.
- len_aad=0, len_pt=0, SOP@0 → length at 1, tag at 3, no AAD or data strobes.
- len_pt=4 with `i_valid` low on alternate cycles and gaps in `i_valid_data` → exactly 4 data strobes, length one enabled cycle after the 4th, tag TAG_LATENCY enabled cycles later.
- SOP during DATA block 2 of 5 (new len_pt=1):
  - `o_error` pulse next cycle;
  - no length strobe for the aborted frame;
  - new frame emits 1 data strobe, then length.
- Reset asserted mid-DATA with a tag pending → all outputs 0 immediately; no tag after release.
- len_pt = 2^NB_LEN_DATA−1 → exact block count, no wrap, a single length strobe.
